ram_dump_reader: RTL

Read-side companion to the flip-flop RAM pair, where mem0 holds 8-character names and mem1 holds one tag byte per entry. On `start` it walks every address and reads both RAMs through their read port 1. It pairs the name and tag at each address into a record and streams the records out on a valid/ready interface. The testbench and the debug path use this block to dump memory contents without driving the RAM read ports by hand.

---
 rtl/ram_dump_reader_if.sv | 57 +++++
 rtl/ram_dump_reader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ram_dump_reader_if.sv
// ---------------------------------------------------------------------------
// ram_dump_reader_if
//
// Purpose:
//   Bundles the two RAM read ports (mem0 names, mem1 tags) and the outgoing
//   record stream of ram_dump_reader into a single interface.
//
// Signals:
//   en_r1_n_mem0 / en_r1_n_mem1  active-low read enables (reader -> RAM)
//   addr_r1_mem0 / addr_r1_mem1  read addresses             (reader -> RAM)
//   data_r1_mem0 / data_r1_mem1  read data, valid one cycle after the
//                                enable/address cycle        (RAM -> reader)
//   out_valid                    record valid                (reader -> sink)
//   out_ready                    sink accepts the record     (sink -> reader)
//   out_addr / out_name / out_tag  record payload            (reader -> sink)
//
// Modports:
//   master  the reader's view (drives enables, addresses and the record)
//   slave   the RAM/sink view
// ---------------------------------------------------------------------------
interface ram_dump_reader_if #(
    parameter int ADDRWIDTH  = 3,
    parameter int WIDTH_MEM0 = 64,
    parameter int WIDTH_MEM1 = 8
);
    logic                  en_r1_n_mem0;
    logic [ADDRWIDTH-1:0]  addr_r1_mem0;
    logic [WIDTH_MEM0-1:0] data_r1_mem0;

    logic                  en_r1_n_mem1;
    logic [ADDRWIDTH-1:0]  addr_r1_mem1;
    logic [WIDTH_MEM1-1:0] data_r1_mem1;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDRWIDTH-1:0]  out_addr;
    logic [WIDTH_MEM0-1:0] out_name;
    logic [WIDTH_MEM1-1:0] out_tag;

    modport master (
        output en_r1_n_mem0, addr_r1_mem0,
        input  data_r1_mem0,
        output en_r1_n_mem1, addr_r1_mem1,
        input  data_r1_mem1,
        output out_valid, out_addr, out_name, out_tag,
        input  out_ready
    );

    modport slave (
        input  en_r1_n_mem0, addr_r1_mem0,
        output data_r1_mem0,
        input  en_r1_n_mem1, addr_r1_mem1,
        output data_r1_mem1,
        input  out_valid, out_addr, out_name, out_tag,
        output out_ready
    );
endinterface

// File: rtl/ram_dump_reader.sv
// ---------------------------------------------------------------------------
// ram_dump_reader
//
// Purpose:
//   Walks every address of the name RAM (mem0) and tag RAM (mem1), reading
//   both through their read port 1, and streams each (address, name, tag)
//   record out over a valid/ready handshake. Entries with an all-zero name
//   can optionally be skipped.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    one-cycle scan request, only honoured while idle
//   busy     high while a scan is in progress (READ/CAPTURE/SEND)
//   done     one-cycle pulse when a scan finishes
//   rec_cnt  records emitted by the last scan, held until the next start
//   bus      ram_dump_reader_if.master: RAM read ports and record stream
// ---------------------------------------------------------------------------
module ram_dump_reader #(
    parameter int ADDRWIDTH  = 3,
    parameter int WIDTH_MEM0 = 64,
    parameter int WIDTH_MEM1 = 8,
    parameter int SKIP_ZERO  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH:0]   rec_cnt,
    ram_dump_reader_if.master    bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDRWIDTH-1:0] PTR_MAX = '1;

    logic [2:0]            state_q,    state_d;
    logic [ADDRWIDTH-1:0]  ptr_q,      ptr_d;
    logic [ADDRWIDTH:0]    rec_cnt_q,  rec_cnt_d;
    logic [ADDRWIDTH-1:0]  out_addr_q, out_addr_d;
    logic [WIDTH_MEM0-1:0] out_name_q, out_name_d;
    logic [WIDTH_MEM1-1:0] out_tag_q,  out_tag_d;

    // Next-state logic for the scan. The pointer only advances after an
    // address has been fully handled (skipped in CAPTURE or handed off in
    // SEND), and the scan ends at the last address instead of wrapping.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rec_cnt_d  = rec_cnt_q;
        out_addr_d = out_addr_q;
        out_name_d = out_name_q;
        out_tag_d  = out_tag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d     = '0;
                    rec_cnt_d = '0;
                    state_d   = S_READ;
                end
            end

            S_READ: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                out_name_d = bus.data_r1_mem0;
                out_tag_d  = bus.data_r1_mem1;
                out_addr_d = ptr_q;
                if ((SKIP_ZERO != 0) && (bus.data_r1_mem0 == '0)) begin
                    if (ptr_q == PTR_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (bus.out_ready) begin
                    rec_cnt_d = rec_cnt_q + 1'b1;
                    if (ptr_q == PTR_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and record registers. Reset drops any record in flight without
    // producing a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rec_cnt_q  <= '0;
            out_addr_q <= '0;
            out_name_q <= '0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rec_cnt_q  <= rec_cnt_d;
            out_addr_q <= out_addr_d;
            out_name_q <= out_name_d;
            out_tag_q  <= out_tag_d;
        end
    end

    // Both RAMs see the same enable and address; enable is asserted only in
    // READ so each address is read exactly once per scan.
    assign bus.en_r1_n_mem0 = (state_q != S_READ);
    assign bus.en_r1_n_mem1 = (state_q != S_READ);
    assign bus.addr_r1_mem0 = ptr_q;
    assign bus.addr_r1_mem1 = ptr_q;

    assign bus.out_valid = (state_q == S_SEND);
    assign bus.out_addr  = out_addr_q;
    assign bus.out_name  = out_name_q;
    assign bus.out_tag   = out_tag_q;

    assign busy    = (state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_SEND);
    assign done    = (state_q == S_DONE);
    assign rec_cnt = rec_cnt_q;

endmodule
